mult_fu_pipe: RTL and testbench
===============================

# mult_fu_pipe

Four-stage pipelined 32x32 integer multiplier functional unit. It sits directly downstream of the issue stage's multiply FIFO, with two instances fed on the MULT_1/MULT_2 slots. It advertises per-cycle readiness back to the issue stage, accepts at most one operation per cycle, and presents finished results to the complete stage under a valid/grant handshake. It flushes all in-flight work on a branch squash.

## Interface
Parameters:
- XLEN, 32, operand and result width.
- TAG_W, 6, physical destination register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operation presented by the issue FIFO.
- in_opa  in  XLEN  multiplicand (rs1 value).
- in_opb  in  XLEN  multiplier (rs2 value).
- in_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- in_dest_tag  in  TAG_W  destination physical register.
- in_rob_idx  in  ROB_W  ROB entry of the operation.
- fu_ready  out  1  unit accepts an operation this cycle (combinational).
- squash  in  1  branch mispredict flush.
- out_valid  out  1  result held in the output stage.
- out_result  out  XLEN  final result.
- out_dest_tag  out  TAG_W  tag of the result.
- out_rob_idx  out  ROB_W  ROB index of the result.
- out_grant  in  1  complete stage consumes the output this cycle.

## Operation
- Pipeline registers P0..P3 each hold: valid, 64-bit mcand, 64-bit mplier, 64-bit partial sum, func, dest_tag, rob_idx. P3 is the output stage.
- Operand extension to 64 bits at entry:
  - opa is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - opb is sign-extended for MULH only, zero-extended otherwise.
- Stage k (k=0..3) adds mcand * mplier[16k+15:16k] << 16k to the partial sum. Chunk product is unsigned 64x16, and all arithmetic is modulo 2^64.
  - P0 captures the stage-0 sum computed from the inputs.
  - P1, P2 and P3 each add their own chunk.
  - P3 holds the complete 64-bit product.
- Result selection: out_result = product[31:0] for MUL; product[63:32] for the other three functions.
- advance = ~P3.valid | out_grant. When advance=1, all stages shift one position. When advance=0, all stages hold, including bubbles; there is no bubble collapse.
- fu_ready = advance & ~squash.
- Accept occurs when in_valid & fu_ready; P0.valid takes the accept value on an advancing edge.
- in_valid while fu_ready=0 is ignored, and no state changes. The issue stage guarantees it never presents in that case.
- out_grant while out_valid=0 is ignored.
- Squash: at the next edge, all valid bits clear, including P3, and any concurrent in_valid is dropped. Squash has priority over accept and grant. The complete stage ignores out_valid in a squash cycle.

## Timing
- Reset: all valid bits 0 and all data/tag fields 0. Consequently out_valid=0, out_result=0, out_dest_tag=0, out_rob_idx=0, and fu_ready=1 in the first cycle after reset.
- Latency: an operation accepted in cycle N has out_valid=1 in cycle N+4 when no stall occurs.
- Throughput: one operation per cycle while out_grant stays asserted or the output slot stays empty.
- Stall: P3 valid and out_grant=0 gives fu_ready=0 in the same cycle. The stall holds all stages and outputs stable until the grant arrives.
- Grant with a new accept in the same cycle is legal. The pipeline shifts, and the new operation enters P0.
- Back-to-back grants drain one result per cycle.
- A squash in cycle N gives out_valid=0 and all stages empty at N+1. fu_ready returns to 1 at N+1.
- rst mid-operation behaves the same as squash and also zeroes all data.

## Test plan
- Single MUL: opa=7, opb=6 accepted at cycle 1 with out_grant held high -> out_valid at cycle 5 with result 42, dest_tag and rob_idx echoed; out_valid=0 at cycle 6.
- Signed high products:
  - MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
  - MULHU same operands -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
  - MUL 0x80000000 x 2 -> 0x00000000.
- Throughput: 8 back-to-back accepts with out_grant=1 -> 8 consecutive out_valid cycles, in order, with correct tags.
- Backpressure: 4 ops in flight, out_grant=0 for 3 cycles -> fu_ready=0, and outputs stay stable during the stall. Each subsequent grant releases one result in order, with no loss or duplication.
- Squash with a full pipeline and simultaneous in_valid -> next cycle out_valid=0, no stale results later, fu_ready=1. A post-squash op with operands 3 and 5 yields 15 four cycles after its accept.
- Reset mid-stream with P1/P3 valid -> next cycle all outputs 0 and fu_ready=1.

Source files
------------

// File: rtl/mult_fu_pipe.sv
// Four-stage pipelined 32x32 multiplier FU: one 16-bit multiplier chunk is folded into
// the partial sum per stage, with valid/grant handshake on the output stage and squash flush.
module mult_fu_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int ROB_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic [1:0]       in_func,
    input  logic [TAG_W-1:0] in_dest_tag,
    input  logic [ROB_W-1:0] in_rob_idx,
    output logic             fu_ready,
    input  logic             squash,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_dest_tag,
    output logic [ROB_W-1:0] out_rob_idx,
    input  logic             out_grant
);
    localparam int PW = 2 * XLEN;
    localparam int CW = PW / 4;

    typedef enum logic [1:0] {
        F_MUL    = 2'd0,
        F_MULH   = 2'd1,
        F_MULHSU = 2'd2,
        F_MULHU  = 2'd3
    } func_e;

    // P3 only needs the finished sum, so operands are carried through P0..P2 only.
    logic [3:0]       vld;
    logic [PW-1:0]    psum   [4];
    logic [PW-1:0]    mcand  [3];
    logic [PW-1:0]    mplier [3];
    func_e            func   [4];
    logic [TAG_W-1:0] tag    [4];
    logic [ROB_W-1:0] rob    [4];

    func_e         in_func_e;
    logic          sx_a;
    logic          sx_b;
    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    logic [PW-1:0] sum_nxt [4];
    logic          advance;

    function automatic logic [PW-1:0] chunk_add(input logic [PW-1:0] sum,
                                                input logic [PW-1:0] mc,
                                                input logic [PW-1:0] mp,
                                                input int unsigned   k);
        logic [PW-1:0] digit;
        digit          = '0;
        digit[CW-1:0]  = mp[CW*k +: CW];
        return sum + ((mc * digit) << (CW * k));
    endfunction

    always_comb begin
        in_func_e = func_e'(in_func);
        sx_a      = (in_func_e == F_MULH) || (in_func_e == F_MULHSU);
        sx_b      = (in_func_e == F_MULH);
        ext_a     = {{XLEN{sx_a & in_opa[XLEN-1]}}, in_opa};
        ext_b     = {{XLEN{sx_b & in_opb[XLEN-1]}}, in_opb};
        sum_nxt[0] = chunk_add('0, ext_a, ext_b, 0);
        for (int unsigned k = 1; k < 4; k++) begin
            sum_nxt[k] = chunk_add(psum[k-1], mcand[k-1], mplier[k-1], k);
        end
    end

    assign advance  = ~vld[3] | out_grant;
    assign fu_ready = advance & ~squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                psum[k] <= '0;
                func[k] <= F_MUL;
                tag[k]  <= '0;
                rob[k]  <= '0;
            end
            for (int unsigned k = 0; k < 3; k++) begin
                mcand[k]  <= '0;
                mplier[k] <= '0;
            end
        end else if (squash) begin
            vld <= '0;
        end else if (advance) begin
            vld       <= {vld[2:0], in_valid};
            psum[0]   <= sum_nxt[0];
            mcand[0]  <= ext_a;
            mplier[0] <= ext_b;
            func[0]   <= in_func_e;
            tag[0]    <= in_dest_tag;
            rob[0]    <= in_rob_idx;
            for (int unsigned k = 1; k < 4; k++) begin
                psum[k] <= sum_nxt[k];
                func[k] <= func[k-1];
                tag[k]  <= tag[k-1];
                rob[k]  <= rob[k-1];
            end
            for (int unsigned k = 1; k < 3; k++) begin
                mcand[k]  <= mcand[k-1];
                mplier[k] <= mplier[k-1];
            end
        end
    end

    assign out_valid    = vld[3];
    assign out_result   = (func[3] == F_MUL) ? psum[3][XLEN-1:0] : psum[3][PW-1:XLEN];
    assign out_dest_tag = tag[3];
    assign out_rob_idx  = rob[3];

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Self-checking bench for mult_fu_pipe: directed latency/stall/squash/reset scenarios
// plus randomized traffic against a slot-level reference model with arithmetic results.
module tb_mult_fu_pipe;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int ROB_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [XLEN-1:0]  in_opa;
    logic [XLEN-1:0]  in_opb;
    logic [1:0]       in_func;
    logic [TAG_W-1:0] in_dest_tag;
    logic [ROB_W-1:0] in_rob_idx;
    logic             fu_ready;
    logic             squash;
    logic             out_valid;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_dest_tag;
    logic [ROB_W-1:0] out_rob_idx;
    logic             out_grant;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_fu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_opa(in_opa), .in_opb(in_opb),
        .in_func(in_func), .in_dest_tag(in_dest_tag), .in_rob_idx(in_rob_idx),
        .fu_ready(fu_ready), .squash(squash), .out_valid(out_valid),
        .out_result(out_result), .out_dest_tag(out_dest_tag), .out_rob_idx(out_rob_idx),
        .out_grant(out_grant)
    );

    function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] f);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f)
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; squash = 1'b0; out_grant = 1'b0;
        in_opa = '0; in_opb = '0; in_func = '0; in_dest_tag = '0; in_rob_idx = '0;
        cycle(); cycle();
        rst = 1'b0;
        #4;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        tests++; if (out_result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want 0", out_result); end
        tests++; if (out_dest_tag !== 6'd0) begin fails++; $display("FAIL reset_tag: got %0d want 0", out_dest_tag); end
        tests++; if (out_rob_idx !== 5'd0) begin fails++; $display("FAIL reset_rob: got %0d want 0", out_rob_idx); end
        tests++; if (fu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", fu_ready); end
        cycle();
    endtask

    task automatic test_single_mul();
        out_grant = 1'b1;
        in_valid = 1'b1; in_opa = 32'd7; in_opb = 32'd6; in_func = 2'd0;
        in_dest_tag = 6'd17; in_rob_idx = 5'd9;
        #4;
        tests++; if (fu_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %0b want 1", fu_ready); end
        cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #4;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early c%0d: got %0b want 0", c, out_valid); end
            cycle();
        end
        #4;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        tests++; if (out_result !== 32'd42) begin fails++; $display("FAIL single_result: got %0d want 42", out_result); end
        tests++; if (out_dest_tag !== 6'd17 || out_rob_idx !== 5'd9) begin
            fails++; $display("FAIL single_ids: got tag %0d rob %0d want 17 9", out_dest_tag, out_rob_idx); end
        cycle();
        #4;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %0b want 0", out_valid); end
        cycle();
    endtask

    task automatic test_signed();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] ve [4];
        logic [1:0]  vf [4];
        va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002};
        vf = '{2'd1, 2'd3, 2'd2, 2'd0};
        ve = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        out_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_opa = va[i]; in_opb = vb[i]; in_func = vf[i];
            in_dest_tag = 6'(i + 40); in_rob_idx = 5'(i + 1);
            cycle();
            in_valid = 1'b0;
            cycle(); cycle(); cycle();
            #4;
            tests++; if (out_valid !== 1'b1 || out_result !== ve[i]) begin
                fails++; $display("FAIL signed_%0d: got v%0b %h want v1 %h", i, out_valid, out_result, ve[i]); end
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      oa [8];
        logic [31:0]      ob [8];
        logic [1:0]       of [8];
        logic [TAG_W-1:0] ot [8];
        for (int i = 0; i < 8; i++) begin
            oa[i] = rand_op(); ob[i] = rand_op(); of[i] = 2'($urandom_range(3)); ot[i] = 6'($urandom);
        end
        out_grant = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; in_opa = oa[c]; in_opb = ob[c]; in_func = of[c];
                in_dest_tag = ot[c]; in_rob_idx = 5'(c);
            end else begin
                in_valid = 1'b0;
            end
            #4;
            tests++; if (fu_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready c%0d: got %0b want 1", c, fu_ready); end
            if (c >= 4 && c < 12) begin
                tests++;
                if (out_valid !== 1'b1 || out_result !== ref_mult(oa[c-4], ob[c-4], of[c-4]) ||
                    out_dest_tag !== ot[c-4] || out_rob_idx !== 5'(c-4)) begin
                    fails++;
                    $display("FAIL b2b_out c%0d: got v%0b %h tag %0d rob %0d want v1 %h tag %0d rob %0d",
                             c, out_valid, out_result, out_dest_tag, out_rob_idx,
                             ref_mult(oa[c-4], ob[c-4], of[c-4]), ot[c-4], c - 4);
                end
            end else begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle c%0d: got %0b want 0", c, out_valid); end
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] oa [4];
        logic [31:0] ob [4];
        logic [1:0]  of [4];
        int          k;
        for (int i = 0; i < 4; i++) begin
            oa[i] = rand_op(); ob[i] = rand_op(); of[i] = 2'($urandom_range(3));
        end
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                out_grant = 1'b1; in_valid = 1'b1; in_opa = oa[c]; in_opb = ob[c]; in_func = of[c];
                in_dest_tag = 6'(c + 20); in_rob_idx = 5'(c + 10);
            end else if (c < 7) begin
                out_grant = 1'b0; in_valid = (c == 5);
                in_opa = 32'd99; in_opb = 32'd99; in_func = 2'd0; in_dest_tag = 6'd63; in_rob_idx = 5'd31;
            end else begin
                out_grant = 1'b1; in_valid = 1'b0;
            end
            #4;
            if (c >= 4 && c < 11) begin
                k = (c < 7) ? 0 : c - 7;
                tests++;
                if (out_valid !== 1'b1 || out_result !== ref_mult(oa[k], ob[k], of[k]) ||
                    out_dest_tag !== 6'(k + 20) || out_rob_idx !== 5'(k + 10)) begin
                    fails++;
                    $display("FAIL bp_out c%0d: got v%0b %h tag %0d rob %0d want v1 %h tag %0d rob %0d",
                             c, out_valid, out_result, out_dest_tag, out_rob_idx,
                             ref_mult(oa[k], ob[k], of[k]), k + 20, k + 10);
                end
                tests++; if (fu_ready !== (c >= 7)) begin
                    fails++; $display("FAIL bp_ready c%0d: got %0b want %0b", c, fu_ready, c >= 7); end
            end else begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_idle c%0d: got %0b want 0", c, out_valid); end
            end
            cycle();
        end
    endtask

    task automatic test_squash();
        out_grant = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_opa = rand_op(); in_opb = rand_op(); in_func = 2'($urandom_range(3));
            in_dest_tag = 6'(c + 1); in_rob_idx = 5'(c + 1);
            cycle();
        end
        in_valid = 1'b1; in_opa = 32'd9; in_opb = 32'd9; squash = 1'b1; out_grant = 1'b0;
        #4;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sq_full: got %0b want 1", out_valid); end
        tests++; if (fu_ready !== 1'b0) begin fails++; $display("FAIL sq_ready_now: got %0b want 0", fu_ready); end
        cycle();
        squash = 1'b0; out_grant = 1'b1;
        in_valid = 1'b1; in_opa = 32'd3; in_opb = 32'd5; in_func = 2'd0; in_dest_tag = 6'd33; in_rob_idx = 5'd21;
        #4;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sq_cleared: got %0b want 0", out_valid); end
        tests++; if (fu_ready !== 1'b1) begin fails++; $display("FAIL sq_ready_after: got %0b want 1", fu_ready); end
        cycle();
        in_valid = 1'b0;
        for (int c = 6; c <= 8; c++) begin
            #4;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sq_stale c%0d: got %0b want 0", c, out_valid); end
            cycle();
        end
        #4;
        tests++; if (out_valid !== 1'b1 || out_result !== 32'd15 || out_dest_tag !== 6'd33 || out_rob_idx !== 5'd21) begin
            fails++; $display("FAIL sq_post: got v%0b %0d tag %0d rob %0d want v1 15 tag 33 rob 21",
                              out_valid, out_result, out_dest_tag, out_rob_idx); end
        cycle();
        #4;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sq_post_drain: got %0b want 0", out_valid); end
        cycle();
    endtask

    task automatic test_reset_mid();
        out_grant = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0 || c == 2);
            in_opa = 32'd1234 + 32'(c); in_opb = 32'd5678; in_func = 2'd0;
            in_dest_tag = 6'd45; in_rob_idx = 5'd27;
            cycle();
        end
        in_valid = 1'b0; out_grant = 1'b0; rst = 1'b1;
        #4;
        tests++; if (out_valid !== 1'b1 || out_result !== 32'd7006652) begin
            fails++; $display("FAIL rstmid_pre: got v%0b %0d want v1 7006652", out_valid, out_result); end
        cycle();
        rst = 1'b0; out_grant = 1'b1;
        #4;
        tests++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_dest_tag !== 6'd0 || out_rob_idx !== 5'd0) begin
            fails++; $display("FAIL rstmid_zero: got v%0b %h tag %0d rob %0d want all 0",
                              out_valid, out_result, out_dest_tag, out_rob_idx); end
        tests++; if (fu_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %0b want 1", fu_ready); end
        cycle();
        for (int c = 6; c <= 8; c++) begin
            #4;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale c%0d: got %0b want 0", c, out_valid); end
            cycle();
        end
    endtask

    task automatic test_random();
        logic             mv   [4];
        logic [31:0]      mr   [4];
        logic [TAG_W-1:0] mt   [4];
        logic [ROB_W-1:0] mrob [4];
        logic             exp_ready;
        rst = 1'b1; in_valid = 1'b0; squash = 1'b0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; mr[i] = '0; mt[i] = '0; mrob[i] = '0; end
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom_range(3) != 0);
            in_opa      = rand_op();
            in_opb      = rand_op();
            in_func     = 2'($urandom_range(3));
            in_dest_tag = 6'($urandom);
            in_rob_idx  = 5'($urandom);
            out_grant   = ($urandom_range(2) != 0);
            squash      = ($urandom_range(24) == 0);
            exp_ready   = (!mv[3] || out_grant) && !squash;
            #4;
            tests++; if (out_valid !== mv[3]) begin fails++; $display("FAIL rnd_valid n%0d: got %0b want %0b", n, out_valid, mv[3]); end
            tests++; if (fu_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready n%0d: got %0b want %0b", n, fu_ready, exp_ready); end
            if (mv[3]) begin
                tests++;
                if (out_result !== mr[3] || out_dest_tag !== mt[3] || out_rob_idx !== mrob[3]) begin
                    fails++;
                    $display("FAIL rnd_data n%0d: got %h tag %0d rob %0d want %h tag %0d rob %0d",
                             n, out_result, out_dest_tag, out_rob_idx, mr[3], mt[3], mrob[3]);
                end
            end
            if (squash) begin
                for (int i = 0; i < 4; i++) mv[i] = 1'b0;
            end else if (!mv[3] || out_grant) begin
                for (int i = 3; i > 0; i--) begin
                    mv[i] = mv[i-1]; mr[i] = mr[i-1]; mt[i] = mt[i-1]; mrob[i] = mrob[i-1];
                end
                mv[0] = in_valid; mr[0] = ref_mult(in_opa, in_opb, in_func);
                mt[0] = in_dest_tag; mrob[0] = in_rob_idx;
            end
            cycle();
        end
        in_valid = 1'b0; squash = 1'b0; out_grant = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_mul();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_squash();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
